ahb_cmd_master: RTL
===================

AHB_CMD_MASTER -- requirements
Module: ahb_cmd_master

Interface
- REQ-001: Parameter CNT_W, default 16, width of the transfer and error statistics counters.
- REQ-002: clk  input  1  clock; all logic on rising edge.
- REQ-003: rst_n  input  1  reset, asynchronous, active-low.
- REQ-004: cmd_valid  input  1  command request from local initiator.
- REQ-005: cmd_ready  output  1  block can accept a command.
- REQ-006: cmd_write  input  1  1=write, 0=read.
- REQ-007: cmd_addr  input  32  byte address.
- REQ-008: cmd_wdata  input  32  write data.
- REQ-009: cmd_size  input  3  AHB size code (0=byte, 1=half, 2=word).
- REQ-010: rsp_valid  output  1  response available.
- REQ-011: rsp_ready  input  1  response consumed.
- REQ-012: rsp_rdata  output  32  read data (0 for writes and errors).
- REQ-013: rsp_err  output  1  transfer failed (bus ERROR or misaligned).
- REQ-014: haddr  output  32  AHB address.
- REQ-015: htrans  output  2  AHB transfer type (2'b00 IDLE, 2'b10 NONSEQ).
- REQ-016: hwrite  output  1  AHB direction.
- REQ-017: hsize  output  3  AHB size.
- REQ-018: hburst  output  3  tied to 3'b000 (SINGLE).
- REQ-019: hwdata  output  32  AHB write data.
- REQ-020: hrdata  input  32  AHB read data.
- REQ-021: hready  input  1  AHB transfer-done / bus-ready.
- REQ-022: hresp  input  2  AHB response (2'b00 OKAY, 2'b01 ERROR).
- REQ-023: txn_cnt  output  CNT_W  completed bus transfers, saturating.
- REQ-024: err_cnt  output  CNT_W  error responses (bus + misaligned), saturating.

Function
- REQ-025: FSM states IDLE, ADDR, DATA, RESP; one outstanding transfer at a time.
- REQ-026: cmd_ready SHALL be 1 only in IDLE; command accepted on cmd_valid && cmd_ready, fields registered.
- REQ-027: Misaligned command (size>2, size=1 with addr[0]=1, size=2 with addr[1:0]!=0) SHALL skip the bus, go directly to RESP with rsp_err=1, rsp_rdata=0, and increment err_cnt only.
- REQ-028: ADDR: drive htrans=NONSEQ, haddr/hwrite/hsize from command; hold all stable until hready=1, then go to DATA.
- REQ-029: DATA: htrans=IDLE; hwdata=cmd_wdata for writes (0 for reads), held stable until hready=1.
- REQ-030: DATA completion on hready=1: hresp=OKAY -> rsp_err=0, rsp_rdata=hrdata (read) or 0 (write); hresp=ERROR -> rsp_err=1, rsp_rdata=0; go to RESP.
- REQ-031: hresp=ERROR with hready=0 (first error cycle) SHALL keep DATA state; htrans stays IDLE.
- REQ-032: RESP: rsp_valid=1, rsp_rdata/rsp_err stable until rsp_ready=1, then IDLE the next cycle.
- REQ-033: Zero-wait-state latency: accept at cycle N -> NONSEQ at N+1 -> data phase N+2 -> rsp_valid at N+3.
- REQ-034: Each wait state (hready=0) in ADDR or DATA adds exactly one cycle.
- REQ-035: txn_cnt increments once per bus completion (OKAY or ERROR); err_cnt per rsp_err=1; both saturate at all-ones, no wrap.

Reset
- REQ-036: On rst_n=0: state IDLE, htrans=IDLE, haddr/hwdata/hsize/hwrite=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, counters=0; cmd_ready=1 after release.
- REQ-037: Reset mid-transfer SHALL abandon it with no response and no counter update.

Verification
- REQ-038: Write addr 0x08, data 0x3, size 2, hready=1 always -> NONSEQ at N+1, hwdata=0x3 at N+2, rsp_valid at N+3, rsp_err=0, txn_cnt=1.
- REQ-039: Read addr 0x00, slave drives hrdata=0x1234 with 2 data-phase wait states -> rsp_valid at N+5, rsp_rdata=0x1234.
- REQ-040: Read with hresp=ERROR two-cycle (hready 0 then 1) -> rsp_err=1, rsp_rdata=0, txn_cnt=1, err_cnt=1.
- REQ-041: Write size 2 at addr 0x06 -> htrans stays IDLE throughout, rsp_err=1 at N+1, txn_cnt=0, err_cnt=1.
- REQ-042: rsp_ready held 0 for 5 cycles with cmd_valid=1 -> cmd_ready=0, rsp stable, no new NONSEQ until rsp_ready=1.
- REQ-043: Assert rst_n=0 during DATA with hready=0 -> all outputs at reset values, no rsp_valid, counters 0.

Source files
------------

// File: rtl/ahb_cmd_master.sv
// Single-outstanding AHB-Lite master that turns local commands into SINGLE transfers.
// Misaligned commands are answered with an error and never reach the bus.
module ahb_cmd_master #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_write,
  input  logic [31:0]      cmd_addr,
  input  logic [31:0]      cmd_wdata,
  input  logic [2:0]       cmd_size,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_rdata,
  output logic             rsp_err,
  output logic [31:0]      haddr,
  output logic [1:0]       htrans,
  output logic             hwrite,
  output logic [2:0]       hsize,
  output logic [2:0]       hburst,
  output logic [31:0]      hwdata,
  input  logic [31:0]      hrdata,
  input  logic             hready,
  input  logic [1:0]       hresp,
  output logic [CNT_W-1:0] txn_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HRESP_OKAY    = 2'b00;

  state_t           r_state, w_next;
  logic             r_write;
  logic [31:0]      r_addr, r_wdata, r_rdata;
  logic [2:0]       r_size;
  logic             r_err;
  logic [CNT_W-1:0] r_txn_cnt, r_err_cnt;
  logic             w_accept, w_misaligned, w_data_done, w_bus_err, w_err_inc;

  assign w_accept    = cmd_valid && (r_state == S_IDLE);
  assign w_data_done = (r_state == S_DATA) && hready;
  assign w_bus_err   = (hresp != HRESP_OKAY);
  assign w_err_inc   = (w_accept && w_misaligned) || (w_data_done && w_bus_err);

  always_comb begin
    w_misaligned = 1'b0;
    case (cmd_size)
      3'd0:    w_misaligned = 1'b0;
      3'd1:    w_misaligned = cmd_addr[0];
      3'd2:    w_misaligned = |cmd_addr[1:0];
      default: w_misaligned = 1'b1;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // NOTE: every output of this block is defaulted first, so no path can infer a latch.
  always_comb begin
    w_next    = r_state;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    htrans    = HTRANS_IDLE;
    hwdata    = '0;
    case (r_state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) w_next = w_misaligned ? S_RESP : S_ADDR;
      end
      S_ADDR: begin
        htrans = HTRANS_NONSEQ;
        if (hready) w_next = S_DATA;
      end
      S_DATA: begin
        hwdata = r_write ? r_wdata : '0;
        if (hready) w_next = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_size  <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_write <= cmd_write;
        r_addr  <= cmd_addr;
        r_wdata <= cmd_wdata;
        r_size  <= cmd_size;
        if (w_misaligned) begin
          r_err   <= 1'b1;
          r_rdata <= '0;
        end
      end
      if (w_data_done) begin
        r_err   <= w_bus_err;
        r_rdata <= (w_bus_err || r_write) ? '0 : hrdata;
      end
    end
  end

  // Statistics stick at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_txn_cnt <= '0;
      r_err_cnt <= '0;
    end else begin
      if (w_data_done && (r_txn_cnt != '1)) r_txn_cnt <= r_txn_cnt + 1'b1;
      if (w_err_inc && (r_err_cnt != '1))   r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  assign haddr     = r_addr;
  assign hwrite    = r_write;
  assign hsize     = r_size;
  assign hburst    = 3'b000;
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;
  assign txn_cnt   = r_txn_cnt;
  assign err_cnt   = r_err_cnt;

endmodule
